// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the FSM state encoding and the EX operand-select codes, so the
// controller, the forwarding selector and the datapath muxes all agree
// on one set of values.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LD_STALL = 2'd1,
    ST_MC_BUSY  = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF    = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_EXMEM = 2'b01;  // operand from EX/MEM result
  localparam logic [1:0] FWD_MEMWB = 2'b10;  // operand from MEM/WB result

endpackage

// File: rtl/fwd_sel.sv
// Forwarding selector for one EX source operand.
// Purely combinational: compares the decode-stage source register against
// the destinations of the instructions currently in EX and MEM and returns
// the operand-select code the instruction will need once it is in EX.
// Ports:
//   rs, rs_used                  decode source register and whether it is read
//   ex_valid/ex_rd/ex_reg_write/ex_mem_read   shadow of the EX stage
//   mem_valid/mem_rd/mem_reg_write            shadow of the MEM stage
//   sel                          FWD_RF / FWD_EXMEM / FWD_MEMWB
module fwd_sel
  import cpu_pkg::*;
#(
  parameter int REG_AW  = 4,
  parameter int R0_ZERO = 1
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              rs_used,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              mem_valid,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  output logic [1:0]        sel
);

  logic src_live;

  // r0 reads are hardwired zero, so they never take a bypass.
  assign src_live = rs_used && !((R0_ZERO != 0) && (rs == '0));

  always_comb begin
    sel = FWD_RF;
    // A load in EX has no result yet; that case is covered by the
    // load-use stall and picks up the MEM/WB path one cycle later.
    if (src_live && ex_valid && ex_reg_write && !ex_mem_read && (ex_rd == rs))
      sel = FWD_EXMEM;
    else if (src_live && mem_valid && mem_reg_write && (mem_rd == rs))
      sel = FWD_MEMWB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage in-order pipeline.
// Tracks shadow copies of the EX, MEM and WB stages and from them drives
// stalls (load-use, multi-cycle EX), branch flushes, EX operand forwarding
// selects and the register-file write port.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   id_*                     decode-slot instruction fields
//   ex_br_taken              branch in EX resolved taken
//   pc_we, ifid_we           PC / IF-ID write enables
//   ifid_flush, idex_flush   clear IF-ID / bubble into ID-EX
//   fwd_a, fwd_b             registered EX operand selects
//   ex_hold                  EX stage frozen (multi-cycle op in progress)
//   wb_we, wb_rd             register-file write port control
//   state                    FSM state (debug)
module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_AW  = 4,
  parameter int MC_LAT  = 4,
  parameter int R0_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_multicycle,
  input  logic              ex_br_taken,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              ex_hold,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_rd,
  output logic [1:0]        state
);

  localparam int              CNT_W   = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
  localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_LAT - 1);
  localparam bit              R0      = (R0_ZERO != 0);
  localparam bit              MC_EN   = (MC_LAT > 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Shadow stages: p0 = EX, p1 = MEM, p2 = WB. mem_read only matters while
  // the instruction sits in EX, so it is not carried further.
  logic              vld_p0, rw_p0, mr_p0;
  logic [REG_AW-1:0] rd_p0;
  logic              vld_p1, rw_p1;
  logic [REG_AW-1:0] rd_p1;
  logic              vld_p2, rw_p2;
  logic [REG_AW-1:0] rd_p2;

  logic       load_use, id_enter, pc_we_c, ifid_we_c;
  logic [1:0] sel_a, sel_b;

  fwd_sel #(.REG_AW(REG_AW), .R0_ZERO(R0_ZERO)) u_fwd_a (
    .rs(id_rs1), .rs_used(id_rs1_used),
    .ex_valid(vld_p0), .ex_rd(rd_p0), .ex_reg_write(rw_p0), .ex_mem_read(mr_p0),
    .mem_valid(vld_p1), .mem_rd(rd_p1), .mem_reg_write(rw_p1),
    .sel(sel_a)
  );

  fwd_sel #(.REG_AW(REG_AW), .R0_ZERO(R0_ZERO)) u_fwd_b (
    .rs(id_rs2), .rs_used(id_rs2_used),
    .ex_valid(vld_p0), .ex_rd(rd_p0), .ex_reg_write(rw_p0), .ex_mem_read(mr_p0),
    .mem_valid(vld_p1), .mem_rd(rd_p1), .mem_reg_write(rw_p1),
    .sel(sel_b)
  );

  assign load_use = (state_q == ST_RUN) && id_valid && vld_p0 && mr_p0 &&
                    !(R0 && (rd_p0 == '0)) &&
                    ((id_rs1_used && (id_rs1 == rd_p0)) ||
                     (id_rs2_used && (id_rs2 == rd_p0)));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_we_c    = 1'b1;
    ifid_we_c  = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    ex_hold    = 1'b0;
    id_enter   = 1'b0;
    case (state_q)
      ST_MC_BUSY: begin
        // Branch input is ignored here: EX holds the multi-cycle op.
        pc_we_c   = 1'b0;
        ifid_we_c = 1'b0;
        ex_hold   = 1'b1;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1))
          state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
        if (ex_br_taken) begin
          // Branch wins over a same-cycle load-use stall: the stalled
          // instruction is on the wrong path anyway.
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          pc_we_c    = 1'b0;
          ifid_we_c  = 1'b0;
          idex_flush = 1'b1;
          state_d    = ST_LD_STALL;
        end
        id_enter = id_valid && !idex_flush;
        if (id_enter && id_multicycle && MC_EN) begin
          state_d = ST_MC_BUSY;
          cnt_d   = MC_LOAD;
        end
      end
    endcase
  end

  assign pc_we   = pc_we_c && !rst;
  assign ifid_we = ifid_we_c && !rst;
  assign state   = state_q;

  // ID -> EX -> MEM -> WB control shadow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      vld_p0  <= 1'b0;
      rw_p0   <= 1'b0;
      mr_p0   <= 1'b0;
      vld_p1  <= 1'b0;
      rw_p1   <= 1'b0;
      vld_p2  <= 1'b0;
      rw_p2   <= 1'b0;
      fwd_a   <= FWD_RF;
      fwd_b   <= FWD_RF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (ex_hold) begin
        vld_p1 <= 1'b0;
      end else begin
        vld_p0 <= id_enter;
        rw_p0  <= id_enter && id_reg_write;
        mr_p0  <= id_enter && id_mem_read;
        fwd_a  <= id_enter ? sel_a : FWD_RF;
        fwd_b  <= id_enter ? sel_b : FWD_RF;
        vld_p1 <= vld_p0;
        rw_p1  <= rw_p0;
      end
      vld_p2 <= vld_p1;
      rw_p2  <= rw_p1;
    end
  end

  // ID -> EX -> MEM -> WB destination registers
  always_ff @(posedge clk) begin
    if (!ex_hold) begin
      rd_p0 <= id_rd;
      rd_p1 <= rd_p0;
    end
    rd_p2 <= rd_p1;
  end

  // Write-through regfile: a WB-stage reader sees the new value directly.
  assign wb_we = vld_p2 && rw_p2 && !(R0 && (rd_p2 == '0));
  assign wb_rd = rd_p2;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic       clk, rst;
  logic       id_valid, id_rs1_used, id_rs2_used;
  logic [3:0] id_rs1, id_rs2, id_rd;
  logic       id_reg_write, id_mem_read, id_multicycle, ex_br_taken;
  logic       pc_we, ifid_we, ifid_flush, idex_flush, ex_hold, wb_we;
  logic [1:0] fwd_a, fwd_b, state;
  logic [3:0] wb_rd;

  int n_pass = 0;
  int n_total = 0;

  pipe_hazard_ctrl #(.REG_AW(4), .MC_LAT(4), .R0_ZERO(1)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_multicycle(id_multicycle), .ex_br_taken(ex_br_taken),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .ex_hold(ex_hold), .wb_we(wb_we), .wb_rd(wb_rd), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ctl = {reg_write, mem_read, multicycle, br_taken}
  // e_ctl = {pc_we, ifid_we, ifid_flush, idex_flush, ex_hold}
  typedef struct {
    logic       v;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [1:0] use_;
    logic [3:0] rd;
    logic [3:0] ctl;
    logic [4:0] e_ctl;
    logic [1:0] e_st;
    logic [1:0] e_fa;
    logic [1:0] e_fb;
    logic       e_wb;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endtask

  task automatic drive(input logic v, input logic [3:0] r1, input logic [3:0] r2,
                       input logic [1:0] u, input logic [3:0] rd, input logic [3:0] ctl);
    @(negedge clk);
    id_valid = v;
    id_rs1 = r1;
    id_rs2 = r2;
    {id_rs1_used, id_rs2_used} = u;
    id_rd = rd;
    {id_reg_write, id_mem_read, id_multicycle, ex_br_taken} = ctl;
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 1'b0; id_rs1 = 4'd0; id_rs2 = 4'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_rd = 4'd0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; id_multicycle = 1'b0; ex_br_taken = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [7:0] ctl_now();
    return 8'({pc_we, ifid_we, ifid_flush, idex_flush, ex_hold});
  endfunction

  initial begin
    //          v     rs1   rs2   use    rd     ctl      e_ctl      st    fa    fb    wb
    tbl[0]  = '{1'b1, 4'd1, 4'd2, 2'b11, 4'd3,  4'b1000, 5'b11000, 2'd0, 2'd0, 2'd0, 1'b0}; // add r3,r1,r2
    tbl[1]  = '{1'b1, 4'd3, 4'd3, 2'b11, 4'd6,  4'b1000, 5'b11000, 2'd0, 2'd0, 2'd0, 1'b0}; // sub r6,r3,r3
    tbl[2]  = '{1'b1, 4'd3, 4'd6, 2'b11, 4'd7,  4'b1000, 5'b11000, 2'd0, 2'd1, 2'd1, 1'b0}; // or r7,r3,r6
    tbl[3]  = '{1'b1, 4'd1, 4'd2, 2'b11, 4'd0,  4'b1000, 5'b11000, 2'd0, 2'd2, 2'd1, 1'b1}; // add r0,r1,r2
    tbl[4]  = '{1'b1, 4'd0, 4'd0, 2'b11, 4'd8,  4'b1000, 5'b11000, 2'd0, 2'd0, 2'd0, 1'b1}; // and r8,r0,r0
    tbl[5]  = '{1'b0, 4'd0, 4'd0, 2'b00, 4'd0,  4'b0000, 5'b11000, 2'd0, 2'd0, 2'd0, 1'b1};
    tbl[6]  = '{1'b0, 4'd0, 4'd0, 2'b00, 4'd0,  4'b0000, 5'b11000, 2'd0, 2'd0, 2'd0, 1'b0}; // r0 write suppressed
    tbl[7]  = '{1'b1, 4'd1, 4'd0, 2'b10, 4'd3,  4'b1100, 5'b11000, 2'd0, 2'd0, 2'd0, 1'b1}; // lw r3
    tbl[8]  = '{1'b1, 4'd3, 4'd5, 2'b11, 4'd4,  4'b1000, 5'b00010, 2'd0, 2'd0, 2'd0, 1'b0}; // add r4,r3,r5 stall
    tbl[9]  = '{1'b1, 4'd3, 4'd5, 2'b11, 4'd4,  4'b1000, 5'b11000, 2'd1, 2'd0, 2'd0, 1'b0}; // LD_STALL
    tbl[10] = '{1'b1, 4'd4, 4'd0, 2'b10, 4'd9,  4'b1100, 5'b11000, 2'd0, 2'd2, 2'd0, 1'b1}; // lw r9,(r4)
    tbl[11] = '{1'b1, 4'd9, 4'd1, 2'b11, 4'd10, 4'b1001, 5'b11110, 2'd0, 2'd1, 2'd0, 1'b0}; // use+branch
    tbl[12] = '{1'b0, 4'd0, 4'd0, 2'b00, 4'd0,  4'b0000, 5'b11000, 2'd0, 2'd0, 2'd0, 1'b1};
    tbl[13] = '{1'b1, 4'd1, 4'd0, 2'b10, 4'd5,  4'b1100, 5'b11000, 2'd0, 2'd0, 2'd0, 1'b1}; // lw r5
    tbl[14] = '{1'b1, 4'd5, 4'd2, 2'b01, 4'd11, 4'b1000, 5'b11000, 2'd0, 2'd0, 2'd0, 1'b0}; // rs1 unused
    tbl[15] = '{1'b0, 4'd0, 4'd0, 2'b00, 4'd0,  4'b0000, 5'b11000, 2'd0, 2'd0, 2'd0, 1'b0};
    tbl[16] = '{1'b0, 4'd0, 4'd0, 2'b00, 4'd0,  4'b0000, 5'b11000, 2'd0, 2'd0, 2'd0, 1'b1};

    // Reset state
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    chk("rst pc_we",   8'(pc_we),   8'd0);
    chk("rst ifid_we", 8'(ifid_we), 8'd0);
    chk("rst wb_we",   8'(wb_we),   8'd0);
    chk("rst state",   8'(state),   8'd0);
    chk("rst fwd_a",   8'(fwd_a),   8'd0);
    chk("rst fwd_b",   8'(fwd_b),   8'd0);
    chk("rst ex_hold", 8'(ex_hold), 8'd0);
    rst = 1'b0;

    // Table-driven sequence: forwarding, r0, load-use, branch override
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].use_, tbl[i].rd, tbl[i].ctl);
      chk($sformatf("row%0d ctl", i),   ctl_now(),       8'(tbl[i].e_ctl));
      chk($sformatf("row%0d state", i), 8'(state),       8'(tbl[i].e_st));
      chk($sformatf("row%0d fwd_a", i), 8'(fwd_a),       8'(tbl[i].e_fa));
      chk($sformatf("row%0d fwd_b", i), 8'(fwd_b),       8'(tbl[i].e_fb));
      chk($sformatf("row%0d wb_we", i), 8'(wb_we),       8'(tbl[i].e_wb));
    end

    // Multi-cycle op, MC_LAT=4: three held cycles, branch ignored while busy
    do_reset();
    drive(1'b1, 4'd1, 4'd2, 2'b11, 4'd12, 4'b1010);           // mul r12
    chk("mc enter state", 8'(state), 8'd0);
    chk("mc enter ctl",   ctl_now(), 8'b11000);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 4'd12, 4'd1, 2'b10, 4'd13, (k == 1) ? 4'b1001 : 4'b1000);
      chk($sformatf("mc busy%0d state", k), 8'(state), 8'd2);
      chk($sformatf("mc busy%0d ctl", k),   ctl_now(), 8'b00001);
      chk($sformatf("mc busy%0d wb_we", k), 8'(wb_we), 8'd0);
    end
    drive(1'b1, 4'd12, 4'd1, 2'b10, 4'd13, 4'b1000);
    chk("mc done state", 8'(state), 8'd0);
    chk("mc done ctl",   ctl_now(), 8'b11000);
    chk("mc done wb_we", 8'(wb_we), 8'd0);
    drive(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 4'b0000);
    chk("mc next fwd_a", 8'(fwd_a), 8'd1);
    chk("mc next wb_we", 8'(wb_we), 8'd0);
    drive(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 4'b0000);
    chk("mc wb_we",      8'(wb_we), 8'd1);
    chk("mc wb_rd",      8'(wb_rd), 8'd12);

    // Asynchronous reset during the second MC_BUSY cycle
    do_reset();
    drive(1'b1, 4'd1, 4'd2, 2'b11, 4'd14, 4'b1000);           // add r14
    drive(1'b1, 4'd1, 4'd2, 2'b11, 4'd12, 4'b1010);           // mul r12
    chk("rmc enter state", 8'(state), 8'd0);
    drive(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 4'b0000);
    chk("rmc busy1 state", 8'(state), 8'd2);
    drive(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 4'b0000);
    chk("rmc busy2 state", 8'(state), 8'd2);
    chk("rmc busy2 wb_we", 8'(wb_we), 8'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rmc rst state",   8'(state),   8'd0);
    chk("rmc rst wb_we",   8'(wb_we),   8'd0);
    chk("rmc rst pc_we",   8'(pc_we),   8'd0);
    chk("rmc rst ifid_we", 8'(ifid_we), 8'd0);
    chk("rmc rst ex_hold", 8'(ex_hold), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 4'd14, 4'd12, 2'b11, 4'd15, 4'b1000);
    chk("post rst state", 8'(state), 8'd0);
    chk("post rst ctl",   ctl_now(), 8'b11000);
    chk("post rst wb_we", 8'(wb_we), 8'd0);
    drive(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 4'b0000);
    chk("post rst fwd_a", 8'(fwd_a), 8'd0);
    chk("post rst fwd_b", 8'(fwd_b), 8'd0);
    chk("post rst wb1",   8'(wb_we), 8'd0);
    drive(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 4'b0000);
    chk("post rst wb2",   8'(wb_we), 8'd0);
    chk("post rst st2",   8'(state), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
